// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per tx_strobe, MSB first, with a CS guard period between bytes.
// Optional feature: define SPI_MASTER_CS_HOLD_EN to let cs_hold keep spi_cs low across bytes.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       tx_strobe,
    input  logic [7:0] tx_data,
    input  logic       cs_hold,
    output logic       busy,
    output logic       rx_strobe,
    output logic [7:0] rx_data,
    output logic       spi_cs,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso
);
    typedef enum logic [2:0] {IDLE, SETUP, CLK_HI, CLK_LO, HOLD, GUARD} state_t;

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [2:0] bit_q;
    logic [7:0] tx_sh_q;
    logic [7:0] rx_sh_q;
    logic [7:0] rx_sh_d;
    logic [1:0] sync_q;
    logic       guard_lo_q;
    logic       hold_en;
    logic       phase_end;

`ifdef SPI_MASTER_CS_HOLD_EN
    assign hold_en = cs_hold;
`else
    logic unused_cs_hold;
    assign unused_cs_hold = cs_hold;
    assign hold_en        = 1'b0;
`endif

    assign phase_end = (cnt_q == 8'(CLK_DIV - 1));
    assign rx_sh_d   = {rx_sh_q[6:0], sync_q[1]};

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            sync_q     <= '0;
            guard_lo_q <= 1'b0;
            busy       <= 1'b0;
            rx_strobe  <= 1'b0;
            rx_data    <= '0;
            spi_cs     <= 1'b1;
            spi_clk    <= 1'b0;
            spi_mosi   <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], spi_miso};
            rx_strobe <= 1'b0;
            case (state_q)
                IDLE, HOLD: begin
                    if (tx_strobe) begin
                        state_q  <= SETUP;
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        tx_sh_q  <= tx_data;
                        spi_mosi <= tx_data[7];
                        spi_cs   <= 1'b0;
                        busy     <= 1'b1;
                    end else if (state_q == HOLD && !hold_en) begin
                        // Leaving HOLD: CS rises at once, then a single guard phase.
                        state_q    <= GUARD;
                        cnt_q      <= '0;
                        guard_lo_q <= 1'b0;
                        spi_cs     <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SETUP, CLK_LO: begin
                    cnt_q <= phase_end ? 8'd0 : cnt_q + 8'd1;
                    if (phase_end) begin
                        state_q <= CLK_HI;
                        spi_clk <= 1'b1;
                    end
                end
                CLK_HI: begin
                    cnt_q <= phase_end ? 8'd0 : cnt_q + 8'd1;
                    if (phase_end) begin
                        spi_clk <= 1'b0;
                        rx_sh_q <= rx_sh_d;
                        if (bit_q == 3'd7) begin
                            rx_data   <= rx_sh_d;
                            rx_strobe <= 1'b1;
                            spi_mosi  <= 1'b1;
                            if (hold_en) begin
                                state_q <= HOLD;
                                busy    <= 1'b0;
                            end else begin
                                state_q    <= GUARD;
                                guard_lo_q <= 1'b1;
                            end
                        end else begin
                            state_q  <= CLK_LO;
                            bit_q    <= bit_q + 3'd1;
                            spi_mosi <= tx_sh_q[6];
                            tx_sh_q  <= {tx_sh_q[6:0], 1'b0};
                        end
                    end
                end
                GUARD: begin
                    cnt_q <= phase_end ? 8'd0 : cnt_q + 8'd1;
                    // Guard after a byte: CLK_DIV cycles CS low, then CLK_DIV cycles CS high.
                    if (phase_end) begin
                        if (guard_lo_q) begin
                            guard_lo_q <= 1'b0;
                            spi_cs     <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: table of loopback/device transfers plus hand sequences for
// ignored strobes, mid-transfer reset and the cs_hold feature (SPI_MASTER_CS_HOLD_EN).
module tb_spi_master;
    localparam int D       = 4;
    localparam int T_RX    = 1 + 16 * D;
    localparam int T_CS    = 1 + 17 * D;
    localparam int T_BUSY  = 1 + 18 * D;

    logic       mclk = 1'b0;
    logic       reset;
    logic       tx_strobe;
    logic [7:0] tx_data;
    logic       cs_hold;
    logic       busy, rx_strobe, spi_cs, spi_clk, spi_mosi, spi_miso;
    logic [7:0] rx_data;

    logic [1:0] miso_sel;
    logic [7:0] dev_tx, dev_rx;
    logic       dev_miso;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    spi_master #(.CLK_DIV(D)) dut (
        .mclk(mclk), .reset(reset), .tx_strobe(tx_strobe), .tx_data(tx_data),
        .cs_hold(cs_hold), .busy(busy), .rx_strobe(rx_strobe), .rx_data(rx_data),
        .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 mclk = ~mclk;

    // Simple mode-0 slave: samples on rising spi_clk, shifts out on falling spi_clk.
    assign dev_miso = dev_tx[7];
    always @(posedge spi_clk) dev_rx <= {dev_rx[6:0], spi_mosi};
    always @(negedge spi_clk) if (!spi_cs) dev_tx <= {dev_tx[6:0], 1'b0};

    assign spi_miso = (miso_sel == 2'd0) ? spi_mosi : (miso_sel == 2'd1) ? dev_miso : 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every rx_strobe must match the oldest outstanding expected byte.
    always @(negedge mclk) begin
        if (reset && rx_strobe) begin
            if (exp_q.size() == 0) chk("rx_unexpected", 1, 0);
            else chk("rx_data", int'(rx_data), int'(exp_q.pop_front()));
        end
    end

    // Starts a byte at cycle 0 and samples each cycle until busy falls (or reset at rst_cyc).
    task automatic run_byte(input logic [7:0] d, input logic h, input logic [7:0] exp_rx,
                            input int inj_cyc, input logic [7:0] inj_d, input int rst_cyc,
                            output int t_rx, output int t_cs, output int t_busy,
                            output int rises, output logic [7:0] mcap, output logic mosi_hi);
        int cyc;
        logic fin, prev_clk;
        t_rx = -1; t_cs = -1; t_busy = -1; rises = 0; mcap = 8'h00; mosi_hi = 1'b0;
        @(posedge mclk); #1;
        tx_data = d; tx_strobe = 1'b1; cs_hold = h;
        exp_q.push_back(exp_rx);
        @(posedge mclk); #1;
        tx_strobe = 1'b0; tx_data = 8'h00;
        cyc = 1; fin = 1'b0; prev_clk = 1'b0;
        while (!fin) begin
            @(negedge mclk);
            if (cyc == rst_cyc) begin
                reset = 1'b0;
                #1;
                chk("rst_cs", int'(spi_cs), 1);
                chk("rst_clk", int'(spi_clk), 0);
                chk("rst_mosi", int'(spi_mosi), 1);
                chk("rst_busy", int'(busy), 0);
                exp_q.delete();
                fin = 1'b1;
            end else begin
                if (cyc == inj_cyc) begin tx_data = inj_d; tx_strobe = 1'b1; end
                if (cyc == inj_cyc + 1) begin tx_data = 8'h00; tx_strobe = 1'b0; end
                if (!prev_clk && spi_clk) begin rises++; mcap = {mcap[6:0], spi_mosi}; end
                prev_clk = spi_clk;
                if (cyc <= 16 * D && spi_mosi) mosi_hi = 1'b1;
                if (rx_strobe && t_rx < 0) t_rx = cyc;
                if (spi_cs && t_cs < 0) t_cs = cyc;
                if (!busy) begin t_busy = cyc; fin = 1'b1; end
                else if (cyc >= 400) begin chk("timeout", cyc, 0); fin = 1'b1; end
                else cyc++;
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
        logic [7:0] dev_load;
        logic [7:0] exp_rx;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int t_rx, t_cs, t_busy, rises;
        logic [7:0] mcap;
        logic mosi_hi;

        vecs[0] = '{8'hA5, 2'd0, 8'h00, 8'hA5};
        vecs[1] = '{8'h9F, 2'd1, 8'h3C, 8'h3C};
        vecs[2] = '{8'h00, 2'd0, 8'h00, 8'h00};
        vecs[3] = '{8'hFF, 2'd0, 8'h00, 8'hFF};
        vecs[4] = '{8'h81, 2'd1, 8'hC3, 8'hC3};

        reset = 1'b0; tx_strobe = 1'b0; tx_data = 8'h00; cs_hold = 1'b0;
        miso_sel = 2'd0; dev_tx = 8'h00; dev_rx = 8'h00;
        repeat (3) @(negedge mclk);
        chk("reset_cs", int'(spi_cs), 1);
        chk("reset_clk", int'(spi_clk), 0);
        chk("reset_mosi", int'(spi_mosi), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_rxd", int'(rx_data), 0);
        chk("reset_rxs", int'(rx_strobe), 0);
        reset = 1'b1;
        repeat (2) @(negedge mclk);

        foreach (vecs[i]) begin
            miso_sel = vecs[i].sel;
            dev_tx = vecs[i].dev_load;
            run_byte(vecs[i].data, 1'b0, vecs[i].exp_rx, -5, 8'h00, -1,
                     t_rx, t_cs, t_busy, rises, mcap, mosi_hi);
            chk($sformatf("v%0d_t_rx", i), t_rx, T_RX);
            chk($sformatf("v%0d_t_cs", i), t_cs, T_CS);
            chk($sformatf("v%0d_t_busy", i), t_busy, T_BUSY);
            chk($sformatf("v%0d_rises", i), rises, 8);
            chk($sformatf("v%0d_mosi", i), int'(mcap), int'(vecs[i].data));
            if (vecs[i].sel == 2'd1) chk($sformatf("v%0d_dev_rx", i), int'(dev_rx), int'(vecs[i].data));
        end

        // Strobe during a transfer must be dropped.
        miso_sel = 2'd0;
        run_byte(8'h00, 1'b0, 8'h00, 10, 8'hFF, -1, t_rx, t_cs, t_busy, rises, mcap, mosi_hi);
        chk("ign_rises", rises, 8);
        chk("ign_mosi_cap", int'(mcap), 0);
        chk("ign_mosi_hi", int'(mosi_hi), 0);
        chk("ign_t_busy", t_busy, T_BUSY);
        repeat (6) @(negedge mclk);
        chk("ign_idle_busy", int'(busy), 0);
        chk("ign_idle_cs", int'(spi_cs), 1);
        chk("ign_idle_mosi", int'(spi_mosi), 1);
        chk("ign_idle_clk", int'(spi_clk), 0);

        // Reset mid-transfer, then a clean loopback byte.
        run_byte(8'hF0, 1'b0, 8'hF0, -5, 8'h00, 30, t_rx, t_cs, t_busy, rises, mcap, mosi_hi);
        repeat (3) @(negedge mclk);
        chk("rst_hold_cs", int'(spi_cs), 1);
        reset = 1'b1;
        repeat (2) @(negedge mclk);
        run_byte(8'h5A, 1'b0, 8'h5A, -5, 8'h00, -1, t_rx, t_cs, t_busy, rises, mcap, mosi_hi);
        chk("post_rst_t_rx", t_rx, T_RX);
        chk("post_rst_mosi", int'(mcap), 8'h5A);
        chk("post_rst_t_busy", t_busy, T_BUSY);

`ifdef SPI_MASTER_CS_HOLD_EN
        run_byte(8'h01, 1'b1, 8'h01, -5, 8'h00, -1, t_rx, t_cs, t_busy, rises, mcap, mosi_hi);
        chk("hold1_t_rx", t_rx, T_RX);
        chk("hold1_t_busy", t_busy, T_RX);
        chk("hold1_cs_rise", t_cs, -1);
        run_byte(8'h02, 1'b1, 8'h02, -5, 8'h00, -1, t_rx, t_cs, t_busy, rises, mcap, mosi_hi);
        chk("hold2_t_rx", t_rx, T_RX);
        chk("hold2_cs_rise", t_cs, -1);
        chk("hold2_mosi", int'(mcap), 8'h02);
        @(posedge mclk); #1;
        cs_hold = 1'b0;
        @(negedge mclk);
        chk("rel_cs_same", int'(spi_cs), 0);
        @(negedge mclk);
        chk("rel_cs_next", int'(spi_cs), 1);
        chk("rel_busy_0", int'(busy), 1);
        for (int k = 1; k < D; k++) begin
            @(negedge mclk);
            chk($sformatf("rel_busy_%0d", k), int'(busy), 1);
        end
        @(negedge mclk);
        chk("rel_busy_end", int'(busy), 0);
        chk("rel_cs_end", int'(spi_cs), 1);
`else
        run_byte(8'h3C, 1'b1, 8'h3C, -5, 8'h00, -1, t_rx, t_cs, t_busy, rises, mcap, mosi_hi);
        chk("nohold_t_rx", t_rx, T_RX);
        chk("nohold_t_cs", t_cs, T_CS);
        chk("nohold_t_busy", t_busy, T_BUSY);
        cs_hold = 1'b0;
`endif

        repeat (4) @(negedge mclk);
        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001: The block SHALL have parameter CLK_DIV, default 4: mclk cycles per spi_clk half-period; legal range 4..255.
REQ-002: The block SHALL have port mclk, input, 1: single clock; all logic on its rising edge.
REQ-003: The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004: The block SHALL have port tx_strobe, input, 1: one-cycle request to transfer tx_data.
REQ-005: The block SHALL have port tx_data, input, 8: byte to shift out MSB first; sampled on an accepted tx_strobe.
REQ-006: The block SHALL have port cs_hold, input, 1: keep spi_cs asserted after the current byte.
REQ-007: The block SHALL have port busy, output, 1: transfer or CS guard in progress; tx_strobe is ignored while high.
REQ-008: The block SHALL have port rx_strobe, output, 1: one-cycle pulse when rx_data is valid.
REQ-009: The block SHALL have port rx_data, output, 8: byte captured from spi_miso.
REQ-010: The block SHALL have port spi_cs, output, 1: chip select, active low.
REQ-011: The block SHALL have port spi_clk, output, 1: SPI clock, mode 0 (idle low).
REQ-012: The block SHALL have port spi_mosi, output, 1: serial data out.
REQ-013: The block SHALL have port spi_miso, input, 1: serial data in, asynchronous; passes through a two-flop synchronizer.

Function
REQ-014: The block SHALL use states IDLE (CS high), SETUP, CLK_HI, CLK_LO, HOLD (CS low, idle) and GUARD; a half-period counter counts CLK_DIV cycles per phase.
REQ-015: On tx_strobe in IDLE or HOLD at cycle 0, cycle 1 SHALL have spi_cs=0, spi_mosi=tx_data[7] and busy=1, and the FSM SHALL enter SETUP.
REQ-016: spi_clk SHALL rise at cycle 1+CLK_DIV and, for bit k (k=0..7), rise at 1+(2k+1)*CLK_DIV and fall at 1+(2k+2)*CLK_DIV.
REQ-017: spi_mosi SHALL change only on cycles where spi_clk falls, presenting the next bit, MSB first.
REQ-018: The synchronized spi_miso SHALL be shifted in on the last cycle of each CLK_HI phase.
REQ-019: At cycle 1+16*CLK_DIV (final fall), rx_strobe SHALL pulse for one cycle with rx_data holding the 8 captured bits, MSB first.
REQ-020: If cs_hold=1 at the final fall, the FSM SHALL enter HOLD with spi_cs=0 and busy=0 on the same cycle as rx_strobe.
REQ-021: If cs_hold=0 at the final fall, the FSM SHALL enter GUARD: spi_cs rises at 1+17*CLK_DIV, busy clears at 1+18*CLK_DIV and the FSM enters IDLE.
REQ-022: In HOLD, if cs_hold=0 and tx_strobe=0, spi_cs SHALL rise on the next cycle and GUARD SHALL run CLK_DIV cycles with busy=1, then go to IDLE.
REQ-023: In HOLD, tx_strobe SHALL take priority over cs_hold=0 that cycle; the new byte follows REQ-015 with spi_cs staying low.
REQ-024: tx_strobe while busy=1 SHALL be ignored with no state change; the ignored tx_data SHALL be discarded.
REQ-025: When idle (IDLE or HOLD), spi_mosi SHALL be 1 and spi_clk SHALL be 0.

Reset
REQ-026: While reset=0, the block SHALL asynchronously force state IDLE, spi_cs=1, spi_clk=0, spi_mosi=1, busy=0, rx_strobe=0, rx_data=8'h00, and clear the counter, shift registers and synchronizer.
REQ-027: A reset mid-transfer SHALL abort it with no rx_strobe; the first tx_strobe after release SHALL start a clean transfer.

Configuration
REQ-028: With SPI_MASTER_CS_HOLD_EN defined, cs_hold SHALL behave per REQ-020..REQ-023.
REQ-029: With SPI_MASTER_CS_HOLD_EN undefined, cs_hold SHALL be ignored (treated as 0), HOLD SHALL be unreachable, and every byte SHALL end with GUARD; the port SHALL remain present.

Verification
REQ-030: The bench SHALL cover: CLK_DIV=4, spi_miso tied to spi_mosi, tx_data=8'hA5, cs_hold=0 -> rx_strobe at cycle 65, rx_data=8'hA5, spi_cs high at 69, busy low at 73.
REQ-031: The bench SHALL cover: spi_miso driven by the team's spi_device model loaded with 8'h3C, master sends 8'h9F -> device rx_data=8'h9F and master rx_data=8'h3C.
REQ-032: The bench SHALL cover: macro defined, cs_hold=1, bytes 8'h01 then 8'h02 -> spi_cs low continuously across both, two rx_strobe pulses, then cs_hold=0 -> spi_cs high one cycle later.
REQ-033: The bench SHALL cover: tx_strobe with 8'hFF issued at cycle 10 of a transfer of 8'h00 -> exactly 8 spi_clk rising edges and spi_mosi=0 throughout the bits.
REQ-034: The bench SHALL cover: reset=0 at cycle 30 of a transfer -> spi_cs=1, spi_clk=0, spi_mosi=1 immediately, no rx_strobe; next transfer of 8'h5A loops back correctly.
REQ-035: The bench SHALL cover: macro undefined, cs_hold=1 -> spi_cs rises after each byte exactly as in REQ-030.
